pixel_scan_issuer: RTL and testbench

- Upstream source stage for the per-pixel intersection pipeline.
- Walks the screen in raster order and issues one (x, y) pixel token per issue slot.
- Captures a snapshot of all block positions at frame start, so positions stay constant for a whole frame.
- Counts returned intersection results to detect frame completion. Throttles issue against an in-flight limit and a downstream stall.

---
 rtl/scan_pkg.sv | 18 +
 rtl/pixel_scan_issuer_inflight_counter.sv | 75 +++++++
 rtl/pixel_scan_issuer.sv | 177 +++++++++++++++++
 tb/tb_pixel_scan_issuer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and widths for the pixel scan issuer: scan state, coordinate,
// block-position and frame-counter widths.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    localparam int X_W  = 11;
    localparam int Y_W  = 10;
    localparam int BX_W = 12;
    localparam int BY_W = 12;
    localparam int BZ_W = 14;
    localparam int FC_W = 16;

endpackage

// File: rtl/pixel_scan_issuer_inflight_counter.sv
// Tracks issued-but-unreturned pixels against a fixed limit; flags a result
// that arrives with nothing outstanding (sticky until reset).
module inflight_counter #(
    parameter int LIMIT = 256,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          err_r;
    logic          err_set_s;

    // Next-count rules: a result with nothing outstanding is an error and never underflows.
    always_comb begin
        count_next_s = count_r;
        err_set_s    = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (count_r != LIMIT_C) begin
                    count_next_s = count_r + ONE_C;
                end else begin
                    count_next_s = count_r;
                end
            end
            2'b01: begin
                if (count_r == {CW{1'b0}}) begin
                    err_set_s = 1'b1;
                end else begin
                    count_next_s = count_r - ONE_C;
                end
            end
            2'b11: begin
                if (count_r == {CW{1'b0}}) begin
                    err_set_s    = 1'b1;
                    count_next_s = ONE_C;
                end else begin
                    count_next_s = count_r;
                end
            end
            default: begin
                count_next_s = count_r;
                err_set_s    = 1'b0;
            end
        endcase
    end

    // Count and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            err_r   <= err_r | err_set_s;
        end
    end

    assign count = count_r;
    assign full  = (count_r >= LIMIT_C);
    assign empty = (count_r == {CW{1'b0}});
    assign err   = err_r;

endmodule

// File: rtl/pixel_scan_issuer.sv
// Raster-order pixel token source with per-frame block snapshot, issue pacing,
// in-flight throttling and frame completion. Optional macro: PIXEL_SCAN_CONTINUOUS_EN.
module pixel_scan_issuer
    import scan_pkg::*;
#(
    parameter int H_PIXELS       = 320,
    parameter int V_PIXELS       = 180,
    parameter int NUM_BLOCKS     = 12,
    parameter int ISSUE_INTERVAL = 1,
    parameter int MAX_INFLIGHT   = 256
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_frame_in,
    input  logic                       stall_in,
    input  logic [NUM_BLOCKS*BX_W-1:0] block_x_in,
    input  logic [NUM_BLOCKS*BY_W-1:0] block_y_in,
    input  logic [NUM_BLOCKS*BZ_W-1:0] block_z_in,
    input  logic                       result_valid_in,
    output logic [X_W-1:0]             x_out,
    output logic [Y_W-1:0]             y_out,
    output logic [NUM_BLOCKS*BX_W-1:0] block_x_out,
    output logic [NUM_BLOCKS*BY_W-1:0] block_y_out,
    output logic [NUM_BLOCKS*BZ_W-1:0] block_z_out,
    output logic                       valid_out,
    output logic                       busy_out,
    output logic                       frame_done_out,
    output logic [FC_W-1:0]            frame_count_out,
    output logic                       err_out
);

    localparam int IW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    localparam logic [X_W-1:0]  X_LAST   = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_PIXELS - 1);
    localparam logic [IW-1:0]   GAP_LOAD = IW'(ISSUE_INTERVAL - 1);
    localparam logic [IW-1:0]   IW_ONE   = IW'(1'b1);
    localparam logic [X_W-1:0]  X_ONE    = X_W'(1'b1);
    localparam logic [Y_W-1:0]  Y_ONE    = Y_W'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1'b1);

    scan_state_e   state_r;
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic [IW-1:0]  gap_r;
    logic           issue_s;
    logic           drain_done_s;
    logic [CW-1:0]  infl_count_s;
    logic           infl_full_s;
    logic           infl_empty_s;
    logic           infl_err_s;

    inflight_counter #(
        .LIMIT (MAX_INFLIGHT),
        .CW    (CW)
    ) u_inflight (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (issue_s),
        .dec   (result_valid_in),
        .count (infl_count_s),
        .full  (infl_full_s),
        .empty (infl_empty_s),
        .err   (infl_err_s)
    );

    // Issue slot and frame-completion decisions for the current cycle.
    always_comb begin
        issue_s      = 1'b0;
        drain_done_s = 1'b0;
        case (state_r)
            ISSUE: begin
                if ((gap_r == {IW{1'b0}}) && !stall_in && !infl_full_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            DRAIN: begin
                // Completion fires on the same edge the last result brings the count to zero.
                if (infl_empty_s || ((infl_count_s == CNT_ONE) && result_valid_in)) begin
                    drain_done_s = 1'b1;
                end else begin
                    drain_done_s = 1'b0;
                end
            end
            default: begin
                issue_s      = 1'b0;
                drain_done_s = 1'b0;
            end
        endcase
    end

    // Frame FSM, raster walk, pacing counter, snapshot and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r         <= IDLE;
            x_r             <= {X_W{1'b0}};
            y_r             <= {Y_W{1'b0}};
            gap_r           <= {IW{1'b0}};
            x_out           <= {X_W{1'b0}};
            y_out           <= {Y_W{1'b0}};
            block_x_out     <= {(NUM_BLOCKS*BX_W){1'b0}};
            block_y_out     <= {(NUM_BLOCKS*BY_W){1'b0}};
            block_z_out     <= {(NUM_BLOCKS*BZ_W){1'b0}};
            valid_out       <= 1'b0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            frame_count_out <= {FC_W{1'b0}};
        end else begin
            valid_out      <= 1'b0;
            frame_done_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_frame_in) begin
                        block_x_out <= block_x_in;
                        block_y_out <= block_y_in;
                        block_z_out <= block_z_in;
                        x_r         <= {X_W{1'b0}};
                        y_r         <= {Y_W{1'b0}};
                        gap_r       <= {IW{1'b0}};
                        busy_out    <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_s) begin
                        valid_out <= 1'b1;
                        x_out     <= x_r;
                        y_out     <= y_r;
                        gap_r     <= GAP_LOAD;
                        if (x_r == X_LAST) begin
                            x_r <= {X_W{1'b0}};
                            if (y_r == Y_LAST) begin
                                y_r     <= {Y_W{1'b0}};
                                state_r <= DRAIN;
                            end else begin
                                y_r <= y_r + Y_ONE;
                            end
                        end else begin
                            x_r <= x_r + X_ONE;
                        end
                    end else if (gap_r != {IW{1'b0}}) begin
                        // Counting down while stalled means no extra credit is banked.
                        gap_r <= gap_r - IW_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_done_s) begin
                        frame_done_out  <= 1'b1;
                        frame_count_out <= frame_count_out + FC_ONE;
`ifdef PIXEL_SCAN_CONTINUOUS_EN
                        block_x_out <= block_x_in;
                        block_y_out <= block_y_in;
                        block_z_out <= block_z_in;
                        x_r         <= {X_W{1'b0}};
                        y_r         <= {Y_W{1'b0}};
                        gap_r       <= {IW{1'b0}};
                        state_r     <= ISSUE;
`else
                        busy_out <= 1'b0;
                        state_r  <= IDLE;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign err_out = infl_err_s;

endmodule

// File: tb/tb_pixel_scan_issuer.sv
// Self-checking bench: two 4x2 issuers (interval 1 / unlimited, interval 3 / limit 2)
// against a frame-level behavioural model plus hand-computed expectations.
module tb_pixel_scan_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Stimulus for instance A and B
    logic rst_a, start_a, stall_a, rv_a, rst_b, start_b, stall_b, rv_b;
    logic [23:0] bxa, bya, bxb, byb;
    logic [27:0] bza, bzb;
    bit ret_en_a = 1'b0, ret_en_b = 1'b0, man_a = 1'b0, man_b = 1'b0;
    logic [4:0] ha = '0, hb = '0;

    // Outputs
    logic [10:0] x_a, x_b;
    logic [9:0]  y_a, y_b;
    logic [23:0] obx_a, oby_a, obx_b, oby_b;
    logic [27:0] obz_a, obz_b;
    logic valid_a, busy_a, done_a, err_a, valid_b, busy_b, done_b, err_b;
    logic [15:0] fc_a, fc_b;

    pixel_scan_issuer #(.H_PIXELS(4), .V_PIXELS(2), .NUM_BLOCKS(2),
                        .ISSUE_INTERVAL(1), .MAX_INFLIGHT(256)) u_a (
        .clk_in(clk), .rst_n_in(rst_a), .start_frame_in(start_a), .stall_in(stall_a),
        .block_x_in(bxa), .block_y_in(bya), .block_z_in(bza), .result_valid_in(rv_a),
        .x_out(x_a), .y_out(y_a), .block_x_out(obx_a), .block_y_out(oby_a),
        .block_z_out(obz_a), .valid_out(valid_a), .busy_out(busy_a),
        .frame_done_out(done_a), .frame_count_out(fc_a), .err_out(err_a));

    pixel_scan_issuer #(.H_PIXELS(4), .V_PIXELS(2), .NUM_BLOCKS(2),
                        .ISSUE_INTERVAL(3), .MAX_INFLIGHT(2)) u_b (
        .clk_in(clk), .rst_n_in(rst_b), .start_frame_in(start_b), .stall_in(stall_b),
        .block_x_in(bxb), .block_y_in(byb), .block_z_in(bzb), .result_valid_in(rv_b),
        .x_out(x_b), .y_out(y_b), .block_x_out(obx_b), .block_y_out(oby_b),
        .block_z_out(obz_b), .valid_out(valid_b), .busy_out(busy_b),
        .frame_done_out(done_b), .frame_count_out(fc_b), .err_out(err_b));

    // Frame-level model: pixel index, edges since last issue, outstanding count.
    typedef struct {
        bit          active;
        int          next_pix;
        int          gap;
        int          infl;
        logic [15:0] frames;
        bit          err;
        bit          valid;
        int          xo;
        int          yo;
        bit          done;
        bit          busy;
        logic [23:0] bx;
        logic [23:0] by;
        logic [27:0] bz;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, int h, int v, int iv, int mx,
                                  logic rst, logic start, logic stall, logic rv,
                                  logic [23:0] bx, logic [23:0] by, logic [27:0] bz);
        mdl_t n;
        bit iss;
        n = m;
        if (!rst) begin
            n = '{default: 0};
            return n;
        end
        n.valid = 1'b0;
        n.done  = 1'b0;
        iss = m.active && (m.next_pix < h * v) && (m.gap >= iv) && !stall && (m.infl < mx);
        if (iss) begin
            n.valid    = 1'b1;
            n.xo       = m.next_pix % h;
            n.yo       = m.next_pix / h;
            n.next_pix = m.next_pix + 1;
            n.gap      = 1;
        end else if (m.gap < iv) begin
            n.gap = m.gap + 1;
        end
        if (rv && m.infl == 0) n.err = 1'b1;
        n.infl = m.infl + (iss ? 1 : 0) - ((rv && m.infl > 0) ? 1 : 0);
        if (!m.active) begin
            if (start) begin
                n.active = 1'b1; n.busy = 1'b1; n.next_pix = 0; n.gap = iv;
                n.bx = bx; n.by = by; n.bz = bz;
            end
        end else if (m.next_pix == h * v && n.infl == 0) begin
            n.done   = 1'b1;
            n.frames = m.frames + 16'd1;
`ifdef PIXEL_SCAN_CONTINUOUS_EN
            n.next_pix = 0; n.gap = iv;
            n.bx = bx; n.by = by; n.bz = bz;
`else
            n.active = 1'b0; n.busy = 1'b0;
`endif
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, 4, 2, 1, 256, rst_a, start_a, stall_a, rv_a, bxa, bya, bza);
        mb <= step(mb, 4, 2, 3, 2, rst_b, start_b, stall_b, rv_b, bxb, byb, bzb);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_valid", valid_a, ma.valid);   chk("b_valid", valid_b, mb.valid);
            chk("a_x", x_a, ma.xo);              chk("b_x", x_b, mb.xo);
            chk("a_y", y_a, ma.yo);              chk("b_y", y_b, mb.yo);
            chk("a_busy", busy_a, ma.busy);      chk("b_busy", busy_b, mb.busy);
            chk("a_done", done_a, ma.done);      chk("b_done", done_b, mb.done);
            chk("a_fcount", fc_a, ma.frames);    chk("b_fcount", fc_b, mb.frames);
            chk("a_err", err_a, ma.err);         chk("b_err", err_b, mb.err);
            chk("a_bx", obx_a, ma.bx);           chk("b_bx", obx_b, mb.bx);
            chk("a_by", oby_a, ma.by);           chk("b_by", oby_b, mb.by);
            chk("a_bz", obz_a, ma.bz);           chk("b_bz", obz_b, mb.bz);
        end
    end

    typedef struct { int x; int y; int c; } pix_t;
    pix_t qa[$], qb[$];
    int   da[$], db[$];
    int   exp_x[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int   exp_y[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    // One cycle: record outputs, then drive result returns for the next edge.
    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
        if (valid_a) qa.push_back('{int'(x_a), int'(y_a), cyc});
        if (valid_b) qb.push_back('{int'(x_b), int'(y_b), cyc});
        if (done_a) da.push_back(cyc);
        if (done_b) db.push_back(cyc);
        ha = {ha[3:0], valid_a};
        hb = {hb[3:0], valid_b};
        rv_a = (ret_en_a & ha[4]) | man_a;
        rv_b = (ret_en_b & hb[1]) | man_b;
    endtask

    int n_stall;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0; rv_a = 1'b0; rv_b = 1'b0;
        bxa = {12'd7, 12'd5}; bya = {12'd3, 12'd2}; bza = {14'd11, 14'd10};
        bxb = {12'd21, 12'd20}; byb = {12'd23, 12'd22}; bzb = {14'd25, 14'd24};
        tick(); tick();
        rst_a = 1'b1; rst_b = 1'b1;
        chk_en = 1'b1;
        chk("rst_valid", valid_a, 0); chk("rst_busy", busy_a, 0);
        chk("rst_bx", obx_a, 0);      chk("rst_fcount", fc_a, 0);
        chk("rst_err", err_a, 0);

        // Instance A: full frame with results returned 5 cycles after each issue
        ret_en_a = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (3) tick();
        bxa[11:0] = 12'd9;
        tick();
        chk("a_snap_hold", obx_a[11:0], 5);
        for (int i = 0; i < 60 && da.size() < 1; i++) tick();
        chk("a_done1_seen", da.size(), 1);
        chk("a_pix_count1", qa.size(), 8);
        if (qa.size() >= 8 && da.size() >= 1) begin
            for (int k = 0; k < 8; k++) begin
                chk("a_pix_x", qa[k].x, exp_x[k]);
                chk("a_pix_y", qa[k].y, exp_y[k]);
                if (k > 0) chk("a_pix_gap", qa[k].c - qa[k-1].c, 1);
            end
            chk("a_done_lat", da[0] - qa[7].c, 5);
        end
        chk("a_fcount1", fc_a, 1);
`ifdef PIXEL_SCAN_CONTINUOUS_EN
        chk("a_busy_cont", busy_a, 1);
        chk("a_snap_recap", obx_a[11:0], 9);
`else
        chk("a_busy_idle", busy_a, 0);
        chk("a_snap_kept", obx_a[11:0], 5);
`endif
        start_a = 1'b1; tick(); start_a = 1'b0; tick();
        chk("a_snap_new", obx_a[11:0], 9);
        for (int i = 0; i < 60 && da.size() < 2; i++) tick();
        chk("a_done2_seen", da.size(), 2);
        chk("a_fcount2", fc_a, 2);
        chk("a_pix_count2", qa.size(), 16);
        if (qa.size() >= 16)
            for (int k = 8; k < 16; k++) chk("a_pix2_x", qa[k].x, exp_x[k-8]);

        // Reset in the middle of issuing, then a stray result sets err
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (3) tick();
        chk("a_mid_valid", valid_a, 1);
        rst_a = 1'b0; ret_en_a = 1'b0; ha = '0;
        tick();
        chk("a_rst_valid", valid_a, 0); chk("a_rst_busy", busy_a, 0);
        chk("a_rst_x", x_a, 0);         chk("a_rst_y", y_a, 0);
        chk("a_rst_bx", obx_a, 0);      chk("a_rst_fc", fc_a, 0);
        rst_a = 1'b1;
        tick();
        man_a = 1'b1; tick(); man_a = 1'b0; tick();
        chk("a_err_set", err_a, 1);
        repeat (3) tick();
        chk("a_err_sticky", err_a, 1);

        // Instance B: limit of 2 with results withheld, then one result
        start_b = 1'b1; tick(); start_b = 1'b0;
        repeat (12) tick();
        chk("b_limit_count", qb.size(), 2);
        if (qb.size() >= 2) begin
            chk("b_spacing01", qb[1].c - qb[0].c, 3);
            chk("b_pix1_x", qb[1].x, 1);
        end
        man_b = 1'b1; tick(); man_b = 1'b0;
        repeat (12) tick();
        chk("b_one_more", qb.size(), 3);
        man_b = 1'b1; tick(); tick(); man_b = 1'b0; ret_en_b = 1'b1;
        tick();
        for (int i = 0; i < 60 && qb.size() < 5; i++) tick();
        chk("b_reach5", qb.size(), 5);
        n_stall = cyc;
        stall_b = 1'b1;
        repeat (4) tick();
        stall_b = 1'b0;
        for (int i = 0; i < 80 && db.size() < 1; i++) tick();
        chk("b_done_seen", db.size(), 1);
        chk("b_pix_count", qb.size(), 8);
        if (qb.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("b_pix_x", qb[k].x, exp_x[k]);
                chk("b_pix_y", qb[k].y, exp_y[k]);
            end
            chk("b_after_stall", qb[5].c, n_stall + 5);
            chk("b_spacing56", qb[6].c - qb[5].c, 3);
            chk("b_spacing67", qb[7].c - qb[6].c, 3);
        end
        chk("b_fcount", fc_b, 1);
        chk("b_err_clear", err_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
